mem_access_unit: RTL and testbench

Memory-side responder for the decoder's MemRead/MemWrite/MemSize/MemUnsigned controls. Executes byte, half and word loads and stores against a word-wide synchronous data RAM. Sub-word stores use read-modify-write; sub-word loads use lane extraction and sign/zero extension. Sits in the MEM stage and stalls the pipeline through req_ready while busy.

---
 rtl/mem_access_unit_pkg.sv | 14 +
 rtl/mem_access_unit_lane_fmt.sv | 25 ++
 rtl/mem_access_unit.sv | 121 ++++++++++++
 tb/tb_mem_access_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: shared size encodings, FSM states and request legality check for the memory access unit.
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int LANE_W = 2;
  typedef enum logic [3:0] {
    IDLE, RD_ISSUE, RD_CAPT, WR_WORD, RMW_RD, RMW_CAPT, RMW_WR, ERR, DONE
  } state_e;
  function automatic logic illegal_req(input logic rd, input logic wr, input logic [1:0] size,
                                       input logic [LANE_W-1:0] low);
    return (rd & wr) | (size == 2'b11) | ((size == SZ_HALF) & low[0]) | ((size == SZ_WORD) & (|low));
  endfunction
endpackage

// File: rtl/mem_access_unit_lane_fmt.sv
// mem_lane_fmt: little-endian lane extraction with sign/zero extension for loads,
// and lane merge of store data into the old RAM word for sub-word stores.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [31:0]       rdata_i,
  input  logic [15:0]       wdata_i,
  input  logic [1:0]        size_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic              unsigned_i,
  output logic [31:0]       load_o,
  output logic [31:0]       merge_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata_i[8*lane_i +: 8];
    h = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_o = (size_i == SZ_BYTE) ? {{24{~unsigned_i & b[7]}}, b} :
             (size_i == SZ_HALF) ? {{16{~unsigned_i & h[15]}}, h} : rdata_i;
    merge_o = rdata_i;
    if (size_i == SZ_BYTE) merge_o[8*lane_i +: 8] = wdata_i[7:0];
    else if (size_i == SZ_HALF) merge_o[16*lane_i[1] +: 16] = wdata_i;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store responder against a word-wide synchronous RAM,
// with read-modify-write for sub-word stores and stall via req_ready.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_AW     = 10,
  parameter int RAM_RD_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemUnsigned,
  input  logic [31:0]       Address,
  input  logic [31:0]       WriteData,
  output logic              resp_valid,
  output logic [31:0]       ReadData,
  output logic              AddrErr,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  state_e              state_q, state_d;
  logic [1:0]          size_q, size_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic                uns_q, uns_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [31:0]         read_data_q, read_data_d;
  logic                resp_valid_q, resp_valid_d;
  logic                addr_err_q, addr_err_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         loaded, merged;
  logic                accept;
  logic                unused_bits;
  assign unused_bits = (^Address[31:MEM_AW+2]) ^ (RAM_RD_LAT != 1);
  assign req_ready   = (state_q == IDLE);
  assign accept      = req_valid & req_ready & (MemRead | MemWrite);
  mem_lane_fmt u_fmt (
    .rdata_i   (mem_rdata),
    .wdata_i   (wdata_q),
    .size_i    (size_q),
    .lane_i    (lane_q),
    .unsigned_i(uns_q),
    .load_o    (loaded),
    .merge_o   (merged)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = illegal_req(MemRead, MemWrite, MemSize, Address[1:0]) ? ERR :
                                      MemRead ? RD_ISSUE : (MemSize == SZ_WORD) ? WR_WORD : RMW_RD;
      RD_ISSUE: state_d = RD_CAPT;
      RD_CAPT:  state_d = DONE;
      WR_WORD:  state_d = DONE;
      RMW_RD:   state_d = RMW_CAPT;
      RMW_CAPT: state_d = RMW_WR;
      RMW_WR:   state_d = DONE;
      default:  state_d = IDLE;
    endcase
    size_d  = accept ? MemSize : size_q;
    lane_d  = accept ? Address[1:0] : lane_q;
    uns_d   = accept ? MemUnsigned : uns_q;
    wdata_d = accept ? WriteData[15:0] : wdata_q;
    addr_d  = accept ? Address[MEM_AW+1:2] : addr_q;
    // RAM port is driven from the state being entered so it is valid for that whole state
    mem_en_d     = state_d inside {RD_ISSUE, WR_WORD, RMW_RD, RMW_WR};
    mem_we_d     = state_d inside {WR_WORD, RMW_WR};
    mem_addr_d   = mem_en_d ? addr_d : '0;
    mem_wdata_d  = (state_d == WR_WORD) ? WriteData : (state_d == RMW_WR) ? merged : '0;
    read_data_d  = (state_d == ERR) ? '0 : (state_q == RD_CAPT) ? loaded : read_data_q;
    resp_valid_d = state_d inside {ERR, DONE};
    addr_err_d   = (state_d == ERR);
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= IDLE;
      size_q       <= '0;
      lane_q       <= '0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      addr_q       <= '0;
      read_data_q  <= '0;
      resp_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      addr_q       <= addr_d;
      read_data_q  <= read_data_d;
      resp_valid_q <= resp_valid_d;
      addr_err_q   <= addr_err_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end
  assign resp_valid = resp_valid_q;
  assign ReadData   = read_data_q;
  assign AddrErr    = addr_err_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven load/store/error vectors with a response scoreboard,
// plus hand sequences for ignored requests and reset during a read-modify-write.
module tb_mem_access_unit;
  import mem_pkg::*;
  logic        Clk = 1'b0, Rst = 1'b1;
  logic        req_valid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, MemUnsigned = 1'b0;
  logic [1:0]  MemSize = '0;
  logic [31:0] Address = '0, WriteData = '0;
  logic        req_ready, resp_valid, AddrErr, mem_en, mem_we;
  logic [31:0] ReadData, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
  logic        pre_we = 1'b0;
  logic [9:0]  pre_a = '0;
  logic [31:0] pre_d = '0;
  logic [31:0] ram [0:1023];
  int          en_cnt = 0, we_cnt = 0;
  int          checks = 0, errors = 0;
  logic [31:0] last_rd = '0;

  typedef struct {
    logic rd, wr; logic [1:0] size; logic uns;
    logic [31:0] addr, wdata, data;
    logic hold, err; int lat, en, we;
    logic chk; int idx; logic [31:0] val;
  } vec_t;
  typedef struct { logic [31:0] data; logic err; int lat; } exp_t;
  exp_t sb[$];
  vec_t vecs[19];

  mem_access_unit #(.MEM_AW(10), .RAM_RD_LAT(1)) dut (
    .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemUnsigned(MemUnsigned),
    .Address(Address), .WriteData(WriteData), .resp_valid(resp_valid), .ReadData(ReadData),
    .AddrErr(AddrErr), .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
    if (mem_en) en_cnt <= en_cnt + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge Clk);
    pre_we = 1'b1; pre_a = idx[9:0]; pre_d = val;
    @(negedge Clk);
    pre_we = 1'b0;
  endtask

  function automatic vec_t ld(input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] d);
    ld = '{rd:1'b1, wr:1'b0, size:sz, uns:u, addr:a, wdata:32'h0, data:d, hold:1'b0, err:1'b0,
           lat:3, en:1, we:0, chk:1'b0, idx:0, val:32'h0};
  endfunction

  function automatic vec_t st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w,
                              input int idx, input logic [31:0] val);
    st = '{rd:1'b0, wr:1'b1, size:sz, uns:1'b0, addr:a, wdata:w, data:32'h0, hold:1'b1, err:1'b0,
           lat:(sz == SZ_WORD) ? 2 : 4, en:(sz == SZ_WORD) ? 1 : 2, we:1, chk:1'b1, idx:idx, val:val};
  endfunction

  function automatic vec_t bad(input logic r, input logic w, input logic [1:0] sz, input logic [31:0] a);
    bad = '{rd:r, wr:w, size:sz, uns:1'b0, addr:a, wdata:32'h0, data:32'h0, hold:1'b0, err:1'b1,
            lat:1, en:0, we:0, chk:1'b0, idx:0, val:32'h0};
  endfunction

  task automatic run(input vec_t v, input int n);
    int en0, we0, cyc;
    exp_t e;
    @(negedge Clk);
    chk($sformatf("v%0d ready", n), {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; MemRead = v.rd; MemWrite = v.wr; MemSize = v.size;
    MemUnsigned = v.uns; Address = v.addr; WriteData = v.wdata;
    e.data = v.hold ? last_rd : v.data; e.err = v.err; e.lat = v.lat;
    sb.push_back(e);
    last_rd = e.data;
    en0 = en_cnt; we0 = we_cnt;
    @(posedge Clk);
    #1 req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (!resp_valid && cyc < 12);
    e = sb.pop_front();
    chk($sformatf("v%0d latency", n), cyc, e.lat);
    chk($sformatf("v%0d ReadData", n), ReadData, e.data);
    chk($sformatf("v%0d AddrErr", n), {31'b0, AddrErr}, {31'b0, e.err});
    chk($sformatf("v%0d mem_en cycles", n), en_cnt - en0, v.en);
    chk($sformatf("v%0d mem_we pulses", n), we_cnt - we0, v.we);
    if (v.chk) chk($sformatf("v%0d ram[%0d]", n, v.idx), ram[v.idx], v.val);
    @(negedge Clk);
    chk($sformatf("v%0d pulse end", n), {30'b0, resp_valid, AddrErr}, 32'd0);
  endtask

  initial begin
    int en0, we0;
    logic seen;
    vecs[0]  = ld(SZ_BYTE, 1'b0, 32'h13, 32'hFFFFFF88);
    vecs[1]  = ld(SZ_HALF, 1'b1, 32'h12, 32'h00008899);
    vecs[2]  = ld(SZ_HALF, 1'b0, 32'h12, 32'hFFFF8899);
    vecs[3]  = ld(SZ_BYTE, 1'b1, 32'h10, 32'h000000BB);
    vecs[4]  = ld(SZ_BYTE, 1'b0, 32'h11, 32'hFFFFFFAA);
    vecs[5]  = ld(SZ_HALF, 1'b0, 32'h10, 32'hFFFFAABB);
    vecs[6]  = st(SZ_WORD, 32'h10, 32'h11223344, 4, 32'h11223344);
    vecs[7]  = st(SZ_BYTE, 32'h11, 32'hDEADBEEF, 4, 32'h1122EF44);
    vecs[8]  = st(SZ_WORD, 32'h20, 32'hCAFEF00D, 8, 32'hCAFEF00D);
    vecs[9]  = ld(SZ_WORD, 1'b0, 32'h20, 32'hCAFEF00D);
    vecs[10] = st(SZ_HALF, 32'h1A, 32'h0000BEEF, 6, 32'hBEEF7788);
    vecs[11] = ld(SZ_BYTE, 1'b1, 32'h1B, 32'h000000BE);
    vecs[12] = bad(1'b1, 1'b0, SZ_HALF, 32'h01);
    vecs[13] = bad(1'b1, 1'b0, SZ_WORD, 32'h06);
    vecs[14] = bad(1'b0, 1'b1, 2'b11, 32'h00);
    vecs[15] = bad(1'b1, 1'b1, SZ_WORD, 32'h10);
    vecs[16] = st(SZ_BYTE, 32'h13, 32'h000000AB, 4, 32'hAB22EF44);
    vecs[17] = ld(SZ_HALF, 1'b0, 32'h1A, 32'hFFFFBEEF);
    vecs[18] = ld(SZ_WORD, 1'b0, 32'h10, 32'hAB22EF44);
    #12;
    chk("reset ctl", {27'b0, req_ready, resp_valid, AddrErr, mem_en, mem_we}, 32'h10);
    chk("reset ReadData", ReadData, 32'h0);
    chk("reset mem_addr", {22'b0, mem_addr}, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    @(negedge Clk);
    Rst = 1'b0;
    preload(4, 32'h8899AABB);
    preload(6, 32'h55667788);
    preload(2, 32'h0BADF00D);
    for (int i = 0; i < 19; i++) run(vecs[i], i);
    // request with neither read nor write must be ignored
    @(negedge Clk);
    en0 = en_cnt;
    req_valid = 1'b1; Address = 32'h10; MemSize = SZ_WORD;
    @(negedge Clk);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      seen = seen | resp_valid | ~req_ready;
    end
    chk("ignored no response", {31'b0, seen}, 32'd0);
    chk("ignored no access", en_cnt - en0, 32'd0);
    // reset while in RMW_CAPT of a half store to 0x08
    @(negedge Clk);
    we0 = we_cnt;
    req_valid = 1'b1; MemWrite = 1'b1; MemSize = SZ_HALF; Address = 32'h08; WriteData = 32'h00001234;
    @(posedge Clk);
    #1 req_valid = 1'b0; MemWrite = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    chk("midrst ctl", {27'b0, req_ready, resp_valid, AddrErr, mem_en, mem_we}, 32'h10);
    chk("midrst ReadData", ReadData, 32'h0);
    chk("midrst mem_addr", {22'b0, mem_addr}, 32'h0);
    chk("midrst mem_wdata", mem_wdata, 32'h0);
    @(negedge Clk);
    Rst = 1'b0;
    last_rd = '0;
    @(negedge Clk);
    chk("midrst no write", we_cnt - we0, 32'd0);
    chk("midrst ram[2]", ram[2], 32'h0BADF00D);
    run(ld(SZ_WORD, 1'b0, 32'h08, 32'h0BADF00D), 19);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
